// File: rtl/divider.sv
// 32-bit signed/unsigned restoring divider with a four-state control FSM.
// Latency: 34 edges from accepted start to results (E0 accept, 32 CALC, FIX); divide-by-zero resolves on E0.
// Backpressure: none; start_i is honoured only in IDLE or DONE and ignored while busy_o is high.
module divider (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic [31:0] src1_i,
  input  logic [31:0] src2_i,
  output logic [31:0] quot_o,
  output logic [31:0] rem_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        div_zero_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  r_state;
  logic [4:0]  r_cnt;
  // Dividend magnitude shifts out of the MSB while quotient bits shift into the LSB.
  logic [31:0] r_dq;
  logic [31:0] r_dvs;
  // Partial remainder stays below the divisor magnitude, so 32 bits hold it;
  // the 33rd bit only exists transiently in the shift/trial path below.
  logic [31:0] r_rem;
  logic        r_neg_q;
  logic        r_neg_r;

  logic        w_accept;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [32:0] w_shift;
  logic [32:0] w_trial;
  logic        w_qbit;

  // Operand capture and trial-subtract datapath.
  always_comb begin
    w_accept = start_i && ((r_state == S_IDLE) || (r_state == S_DONE));
    w_a_neg  = signed_i && src1_i[31];
    w_b_neg  = signed_i && src2_i[31];
    w_a_mag  = w_a_neg ? (32'd0 - src1_i) : src1_i;
    w_b_mag  = w_b_neg ? (32'd0 - src2_i) : src2_i;
    w_shift  = {r_rem, r_dq[31]};
    w_trial  = w_shift - {1'b0, r_dvs};
    w_qbit   = ~w_trial[32];
  end

  assign busy_o = (r_state == S_CALC) || (r_state == S_FIX);
  assign done_o = (r_state == S_DONE);

  // Control FSM, iteration datapath and registered results.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= S_IDLE;
      r_cnt      <= 5'd0;
      r_dq       <= 32'd0;
      r_dvs      <= 32'd0;
      r_rem      <= 32'd0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      quot_o     <= 32'd0;
      rem_o      <= 32'd0;
      div_zero_o <= 1'b0;
    end else begin
      case (r_state)
        S_CALC: begin
          r_rem <= w_qbit ? w_trial[31:0] : w_shift[31:0];
          r_dq  <= {r_dq[30:0], w_qbit};
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          quot_o  <= r_neg_q ? (32'd0 - r_dq) : r_dq;
          rem_o   <= r_neg_r ? (32'd0 - r_rem) : r_rem;
          r_state <= S_DONE;
        end
        default: begin
          // IDLE and DONE both accept a new request; DONE otherwise lasts one cycle.
          if (w_accept) begin
            if (src2_i == 32'd0) begin
              quot_o     <= 32'hFFFF_FFFF;
              rem_o      <= src1_i;
              div_zero_o <= 1'b1;
              r_state    <= S_DONE;
            end else begin
              r_dq       <= w_a_mag;
              r_dvs      <= w_b_mag;
              r_neg_q    <= w_a_neg ^ w_b_neg;
              r_neg_r    <= w_a_neg;
              r_rem      <= 32'd0;
              r_cnt      <= 5'd0;
              div_zero_o <= 1'b0;
              r_state    <= S_CALC;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
// Directed self-checking bench for the divider.
// Inputs change 1 time unit after a rising edge; outputs are sampled at that same point.
// Every bounded wait reports FAIL on expiry and still reaches the summary line.
module tb_divider;

  logic        clk_i;
  logic        rst_i;
  logic        start_i;
  logic        signed_i;
  logic [31:0] src1_i;
  logic [31:0] src2_i;
  logic [31:0] quot_o;
  logic [31:0] rem_o;
  logic        busy_o;
  logic        done_o;
  logic        div_zero_o;

  int errors = 0;
  int checks = 0;

  divider dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .signed_i   (signed_i),
    .src1_i     (src1_i),
    .src2_i     (src2_i),
    .quot_o     (quot_o),
    .rem_o      (rem_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .div_zero_o (div_zero_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Present a request for one edge (E0); returns at E0+1.
  task automatic do_start(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    start_i  = 1'b1;
    signed_i = sgn;
    src1_i   = a;
    src2_i   = b;
    tick();
    start_i  = 1'b0;
  endtask

  // Count edges until done_o, and cycles observed with busy_o high.
  task automatic wait_done(output int cyc, output int busy_cnt, output bit timed_out);
    cyc = 0;
    busy_cnt = 0;
    while (!done_o && cyc < 100) begin
      if (busy_o) busy_cnt++;
      tick();
      cyc++;
    end
    timed_out = !done_o;
  endtask

  task automatic test_reset();
    rst_i = 1'b0; start_i = 1'b0; signed_i = 1'b0; src1_i = 32'd0; src2_i = 32'd0;
    #2;
    checks++; if (quot_o !== 32'd0) begin errors++; $display("FAIL reset_quot got=%h exp=0", quot_o); end
    checks++; if (rem_o !== 32'd0) begin errors++; $display("FAIL reset_rem got=%h exp=0", rem_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done_o); end
    checks++; if (div_zero_o !== 1'b0) begin errors++; $display("FAIL reset_dz got=%b exp=0", div_zero_o); end
    tick();
    // Release reset with a request already pending: the first edge must accept it.
    rst_i = 1'b1;
    start_i = 1'b1; src1_i = 32'd20; src2_i = 32'd4;
    tick();
    start_i = 1'b0;
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL first_start_busy got=%b exp=1", busy_o); end
    begin
      int c, b; bit to;
      wait_done(c, b, to);
      checks++; if (to) begin errors++; $display("FAIL first_start_timeout got=%0d exp=33", c); end
      checks++; if (quot_o !== 32'd5 || rem_o !== 32'd0) begin errors++; $display("FAIL first_start_res got=%h/%h exp=5/0", quot_o, rem_o); end
    end
    tick();
  endtask

  task automatic test_unsigned();
    int c, b; bit to;
    do_start(1'b0, 32'd100, 32'd7);
    wait_done(c, b, to);
    checks++; if (to || c != 33) begin errors++; $display("FAIL u100_7_latency got=%0d exp=33", c); end
    checks++; if (b != 33) begin errors++; $display("FAIL u100_7_busy_cycles got=%0d exp=33", b); end
    checks++; if (quot_o !== 32'd14) begin errors++; $display("FAIL u100_7_quot got=%0d exp=14", quot_o); end
    checks++; if (rem_o !== 32'd2) begin errors++; $display("FAIL u100_7_rem got=%0d exp=2", rem_o); end
    checks++; if (div_zero_o !== 1'b0) begin errors++; $display("FAIL u100_7_dz got=%b exp=0", div_zero_o); end
    tick();
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL done_one_cycle got=%b exp=0", done_o); end
    repeat (3) tick();
    checks++; if (quot_o !== 32'd14 || rem_o !== 32'd2) begin errors++; $display("FAIL hold_results got=%0d/%0d exp=14/2", quot_o, rem_o); end
    // Same bit pattern unsigned: 0xFFFFFFF9 / 2.
    do_start(1'b0, 32'hFFFF_FFF9, 32'd2);
    wait_done(c, b, to);
    checks++; if (to || quot_o !== 32'h7FFF_FFFC || rem_o !== 32'd1) begin errors++; $display("FAIL u_fff9_2 got=%h/%h exp=7ffffffc/1", quot_o, rem_o); end
    tick();
  endtask

  task automatic test_signed();
    int c, b; bit to;
    do_start(1'b1, 32'hFFFF_FFF9, 32'd2);
    wait_done(c, b, to);
    checks++; if (to || quot_o !== 32'hFFFF_FFFD || rem_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL s_m7_2 got=%h/%h exp=fffffffd/ffffffff", quot_o, rem_o); end
    tick();
    do_start(1'b1, 32'd7, 32'hFFFF_FFFE);
    wait_done(c, b, to);
    checks++; if (to || quot_o !== 32'hFFFF_FFFD || rem_o !== 32'd1) begin errors++; $display("FAIL s_7_m2 got=%h/%h exp=fffffffd/1", quot_o, rem_o); end
    tick();
    do_start(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE);
    wait_done(c, b, to);
    checks++; if (to || quot_o !== 32'd3 || rem_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL s_m7_m2 got=%h/%h exp=3/ffffffff", quot_o, rem_o); end
    tick();
  endtask

  task automatic test_div_zero();
    for (int m = 0; m < 2; m++) begin
      do_start(m[0], 32'd5, 32'd0);
      checks++; if (done_o !== 1'b1 || busy_o !== 1'b0) begin errors++; $display("FAIL dz_timing mode=%0d got done=%b busy=%b exp done=1 busy=0", m, done_o, busy_o); end
      checks++; if (quot_o !== 32'hFFFF_FFFF || rem_o !== 32'd5 || div_zero_o !== 1'b1) begin errors++; $display("FAIL dz_result mode=%0d got=%h/%h/%b exp=ffffffff/5/1", m, quot_o, rem_o, div_zero_o); end
      tick();
      checks++; if (done_o !== 1'b0 || busy_o !== 1'b0 || div_zero_o !== 1'b1) begin errors++; $display("FAIL dz_after mode=%0d got done=%b busy=%b dz=%b exp 0/0/1", m, done_o, busy_o, div_zero_o); end
    end
    do_start(1'b0, 32'd9, 32'd3);
    checks++; if (div_zero_o !== 1'b0) begin errors++; $display("FAIL dz_clear got=%b exp=0", div_zero_o); end
    begin
      int c, b; bit to;
      wait_done(c, b, to);
      checks++; if (to || quot_o !== 32'd3 || rem_o !== 32'd0) begin errors++; $display("FAIL dz_then_9_3 got=%h/%h exp=3/0", quot_o, rem_o); end
    end
    tick();
  endtask

  task automatic test_overflow();
    int c, b; bit to;
    do_start(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(c, b, to);
    checks++; if (to || quot_o !== 32'h8000_0000 || rem_o !== 32'd0 || div_zero_o !== 1'b0) begin errors++; $display("FAIL s_min_m1 got=%h/%h dz=%b exp=80000000/0 dz=0", quot_o, rem_o, div_zero_o); end
    tick();
    do_start(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(c, b, to);
    checks++; if (to || quot_o !== 32'd0 || rem_o !== 32'h8000_0000) begin errors++; $display("FAIL u_min_m1 got=%h/%h exp=0/80000000", quot_o, rem_o); end
    tick();
  endtask

  task automatic test_busy_ignore();
    int c, b; bit to;
    do_start(1'b0, 32'd100, 32'd7);
    repeat (9) tick();
    start_i = 1'b1; src1_i = 32'd9; src2_i = 32'd3; signed_i = 1'b1;
    tick();
    start_i = 1'b0; src1_i = 32'hDEAD_BEEF; src2_i = 32'd0;
    wait_done(c, b, to);
    checks++; if (to || c != 23) begin errors++; $display("FAIL ignore_latency got=%0d exp=23", c); end
    checks++; if (quot_o !== 32'd14 || rem_o !== 32'd2 || div_zero_o !== 1'b0) begin errors++; $display("FAIL ignore_result got=%0d/%0d dz=%b exp=14/2 dz=0", quot_o, rem_o, div_zero_o); end
    tick();
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    do_start(1'b0, 32'd100, 32'd7);
    repeat (9) tick();
    start_i = 1'b1; src1_i = 32'd9; src2_i = 32'd3;
    tick();
    start_i = 1'b0;
    repeat (9) tick();
    rst_i = 1'b0;
    #1;
    checks++; if (quot_o !== 32'd0 || rem_o !== 32'd0) begin errors++; $display("FAIL rst_mid_data got=%h/%h exp=0/0", quot_o, rem_o); end
    checks++; if (busy_o !== 1'b0 || done_o !== 1'b0 || div_zero_o !== 1'b0) begin errors++; $display("FAIL rst_mid_ctrl got busy=%b done=%b dz=%b exp 0/0/0", busy_o, done_o, div_zero_o); end
    repeat (2) tick();
    rst_i = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (done_o || busy_o) seen++;
      tick();
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL rst_mid_no_done got=%0d active cycles exp=0", seen); end
  endtask

  task automatic test_back_to_back();
    int c, b; bit to;
    do_start(1'b0, 32'd100, 32'd7);
    wait_done(c, b, to);
    checks++; if (to || quot_o !== 32'd14 || rem_o !== 32'd2) begin errors++; $display("FAIL b2b_first got=%0d/%0d exp=14/2", quot_o, rem_o); end
    do_start(1'b0, 32'd9, 32'd3);
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL b2b_accept got=%b exp=1", busy_o); end
    wait_done(c, b, to);
    checks++; if (to || c + 1 != 34) begin errors++; $display("FAIL b2b_spacing got=%0d exp=34", c + 1); end
    checks++; if (quot_o !== 32'd3 || rem_o !== 32'd0) begin errors++; $display("FAIL b2b_second got=%0d/%0d exp=3/0", quot_o, rem_o); end
    tick();
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset SHALL be asynchronous and active-low.
REQ-002 clk_i  input  1  clock; all state updates on rising edge.
REQ-003 rst_i  input  1  asynchronous active-low reset.
REQ-004 start_i  input  1  request a division; sampled only on a rising edge while state is IDLE or DONE.
REQ-005 signed_i  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start_i.
REQ-006 src1_i  input  32  dividend; sampled with start_i.
REQ-007 src2_i  input  32  divisor; sampled with start_i.
REQ-008 quot_o  output  32  registered quotient.
REQ-009 rem_o  output  32  registered remainder.
REQ-010 busy_o  output  1  high while state is CALC or FIX.
REQ-011 done_o  output  1  high for exactly one cycle while state is DONE.
REQ-012 div_zero_o  output  1  registered; set with results when divisor was zero, cleared on next accepted start.

Function
REQ-013 The FSM SHALL have states IDLE, CALC, FIX, DONE.
REQ-014 IDLE/DONE + start_i=1 + divisor!=0 -> CALC: capture operand magnitudes, sign flags, signed_i; clear iteration counter, partial remainder, div_zero_o.
REQ-015 IDLE/DONE + start_i=1 + divisor==0 -> DONE directly: quot_o=0xFFFFFFFF, rem_o=raw src1_i, div_zero_o=1, all on the same edge.
REQ-016 CALC: one restoring iteration per cycle (shift partial remainder left, bring in next dividend MSB, 33-bit trial subtract of divisor magnitude, keep if non-negative, quotient bit = not borrow); exactly 32 CALC cycles, then -> FIX.
REQ-017 FIX: apply sign correction and register quot_o/rem_o, then -> DONE.
REQ-018 DONE -> IDLE after one cycle unless a new start is accepted (back-to-back allowed).
REQ-019 Latency: start accepted on edge E0 -> CALC E1..E32 -> FIX edge E33 registers results -> done_o high in cycle after E33; divide-by-zero: done_o high in cycle after E0.
REQ-020 Signed mode: operate on magnitudes; quotient negated iff operand signs differ; remainder takes dividend sign; |rem| < |divisor|.
REQ-021 Signed 0x80000000 / 0xFFFFFFFF SHALL give quot_o=0x80000000, rem_o=0 (wrap, no flag).
REQ-022 start_i while busy_o=1 SHALL be ignored; in-flight operation unaffected; operand input changes during CALC have no effect.
REQ-023 quot_o/rem_o/div_zero_o SHALL hold their values from DONE until the next FIX or divide-by-zero update.
REQ-024 All arithmetic modulo 2^32 on outputs; internal partial remainder 33 bits.

Reset
REQ-025 rst_i=0 SHALL immediately force state IDLE, quot_o=0, rem_o=0, busy_o=0, done_o=0, div_zero_o=0, counter=0, regardless of clock.
REQ-026 Reset mid-operation SHALL abandon the operation; no done_o pulse follows release.
REQ-027 First start SHALL be accepted on the first rising edge with rst_i=1.

Verification
REQ-028 Unsigned 100/7, start at E0 -> busy_o 1 for 33 cycles, done_o pulse after E33, quot_o=14, rem_o=2.
REQ-029 Signed -7/2 (0xFFFFFFF9/0x00000002) -> quot_o=0xFFFFFFFD, rem_o=0xFFFFFFFF; signed 7/-2 -> quot_o=0xFFFFFFFD, rem_o=1.
REQ-030 5/0 either mode -> done_o after E0, quot_o=0xFFFFFFFF, rem_o=5, div_zero_o=1, busy_o never high.
REQ-031 0x80000000/0xFFFFFFFF: signed -> quot 0x80000000, rem 0; unsigned -> quot 0, rem 0x80000000.
REQ-032 Start 100/7, pulse start_i with 9/3 at cycle 10, assert rst_i=0 at cycle 20 -> second start ignored, outputs 0 immediately on reset, no done_o after release.
REQ-033 Start 9/3 in the DONE cycle of 100/7 -> first results 14/2 seen with done_o, second done_o 34 cycles later with 3/0.
